// File: rtl/step_bank_pkg.sv
// Shared definitions for the step bank: mode-bit positions, size limits and
// the per-channel register set held in both shadow and active copies.
package step_bank_pkg;

   localparam int STEPM1_BIT   = 0;
   localparam int YFRAC_BIT    = 4;
   localparam int MAX_CHANNELS = 4;
   localparam int MAX_STEP_W   = 24;
   localparam int INC_W        = 8;

   typedef struct packed {
      logic [MAX_STEP_W-1:0] step;
      logic                  stepm1;
      logic                  yfrac;
      logic [INC_W-1:0]      inc;
   } chan_regs_t;

   // Byte pointer wraps after the last byte of the configured step width.
   function automatic logic [1:0] next_ptr(input logic [1:0] ptr, input logic [1:0] last);
      next_ptr = (ptr == last) ? 2'd0 : ptr + 2'd1;
   endfunction

endpackage

// File: rtl/step_bank_if.sv
// Bus bundle between the controller and the step bank.
// Strobes (LDSTP/LDMOD/LDINC/COMMIT) and ADV bits are single-cycle, sampled on
// every rising clock edge with no back-pressure; outputs are registered.
interface step_bank_if #(
   parameter int CHANNELS = 2,
   parameter int STEP_W   = 8
);
   logic [7:0]                 ID;
   logic [1:0]                 CHSEL;
   logic                       LDSTP;
   logic                       LDMOD;
   logic                       LDINC;
   logic                       COMMIT;
   logic [CHANNELS-1:0]        ADV;
   logic [CHANNELS*STEP_W-1:0] STEP;
   logic [CHANNELS-1:0]        STEPM1;
   logic [CHANNELS-1:0]        YFRAC;
   logic [CHANNELS-1:0]        STEP_EN;

   modport master (
      output ID, CHSEL, LDSTP, LDMOD, LDINC, COMMIT, ADV,
      input  STEP, STEPM1, YFRAC, STEP_EN
   );

   modport slave (
      input  ID, CHSEL, LDSTP, LDMOD, LDINC, COMMIT, ADV,
      output STEP, STEPM1, YFRAC, STEP_EN
   );
endinterface

// File: rtl/step_chan.sv
// One step channel: shadow/active register pair, byte-serial step loader,
// fractional accumulator and the registered STEP_EN pulse.
module step_chan
   import step_bank_pkg::*;
#(
   parameter int STEP_W = 8,
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        id,
   input  logic              ld_stp,
   input  logic              ld_mod,
   input  logic              ld_inc,
   input  logic              commit,
   input  logic              adv,
   output logic [STEP_W-1:0] step,
   output logic              stepm1,
   output logic              yfrac,
   output logic              step_en
);

   localparam int         NBYTES   = STEP_W / 8;
   localparam logic [1:0] LAST_PTR = 2'(NBYTES - 1);

   chan_regs_t        sh_q, sh_d;
   chan_regs_t        act_q, act_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              step_en_q, step_en_d;

   logic [1:0]        ptr_eff;
   logic [FRAC_W:0]   sum;
   logic              unused_step_hi;

   always_comb begin
      sh_d    = sh_q;
      ptr_d   = ptr_q;
      ptr_eff = ptr_q;
      // A mode write rewinds the pointer before a same-cycle step byte lands.
      if (ld_mod) begin
         sh_d.stepm1 = id[STEPM1_BIT];
         sh_d.yfrac  = id[YFRAC_BIT];
         ptr_eff     = 2'd0;
         ptr_d       = 2'd0;
      end
      if (ld_stp) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (ptr_eff == 2'(b)) sh_d.step[b*8 +: 8] = id;
         end
         ptr_d = next_ptr(ptr_eff, LAST_PTR);
      end
      if (ld_inc) sh_d.inc = id;
   end

   always_comb begin
      act_d     = act_q;
      acc_d     = acc_q;
      step_en_d = 1'b0;
      sum       = {1'b0, acc_q} + (FRAC_W+1)'(act_q.inc);
      // Commit takes the pre-load shadow and overrides any coincident ADV.
      if (commit) begin
         act_d = sh_q;
         acc_d = '0;
      end else if (adv) begin
         if (act_q.yfrac) begin
            acc_d     = sum[FRAC_W-1:0];
            step_en_d = sum[FRAC_W];
         end else begin
            step_en_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q      <= '0;
         act_q     <= '0;
         ptr_q     <= 2'd0;
         acc_q     <= '0;
         step_en_q <= 1'b0;
      end else begin
         sh_q      <= sh_d;
         act_q     <= act_d;
         ptr_q     <= ptr_d;
         acc_q     <= acc_d;
         step_en_q <= step_en_d;
      end
   end

   assign step           = act_q.step[STEP_W-1:0];
   assign stepm1         = act_q.stepm1;
   assign yfrac          = act_q.yfrac;
   assign step_en        = step_en_q;
   assign unused_step_hi = ^act_q.step;

endmodule

// File: rtl/step_bank.sv
// Bank of independent step channels sharing one load bus; CHSEL steers the
// load strobes, COMMIT and ADV reach every channel directly.
module step_bank
   import step_bank_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int STEP_W   = 8,
   parameter int FRAC_W   = 8
) (
   input  logic       MasterClock,
   input  logic       RESET,
   step_bank_if.slave bus
);

   logic [CHANNELS*STEP_W-1:0] step_all;
   logic [CHANNELS-1:0]        stepm1_all;
   logic [CHANNELS-1:0]        yfrac_all;
   logic [CHANNELS-1:0]        step_en_all;

   for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
      // CHSEL values beyond the last channel match nothing and are dropped.
      logic sel;
      assign sel = (bus.CHSEL == 2'(n));

      step_chan #(
         .STEP_W (STEP_W),
         .FRAC_W (FRAC_W)
      ) u_chan (
         .clk     (MasterClock),
         .rst     (RESET),
         .id      (bus.ID),
         .ld_stp  (sel & bus.LDSTP),
         .ld_mod  (sel & bus.LDMOD),
         .ld_inc  (sel & bus.LDINC),
         .commit  (bus.COMMIT),
         .adv     (bus.ADV[n]),
         .step    (step_all[n*STEP_W +: STEP_W]),
         .stepm1  (stepm1_all[n]),
         .yfrac   (yfrac_all[n]),
         .step_en (step_en_all[n])
      );
   end

   assign bus.STEP    = step_all;
   assign bus.STEPM1  = stepm1_all;
   assign bus.YFRAC   = yfrac_all;
   assign bus.STEP_EN = step_en_all;

endmodule

// File: tb/tb_step_bank.sv
// Bench for step_bank (2 channels, 16-bit steps): directed vectors with
// literal expectations plus a per-cycle comparison against a behavioural model.
module tb_step_bank;

   localparam int CH  = 2;
   localparam int SW  = 16;
   localparam int NBY = SW / 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   step_bank_if #(.CHANNELS(CH), .STEP_W(SW)) bus ();

   step_bank #(.CHANNELS(CH), .STEP_W(SW), .FRAC_W(8)) dut (
      .MasterClock (clk),
      .RESET       (rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: shadow/active values as plain integers.
   int m_sh_step[CH], m_sh_m1[CH], m_sh_yf[CH], m_sh_inc[CH], m_ptr[CH];
   int m_step[CH], m_m1[CH], m_yf[CH], m_inc[CH], m_acc[CH], m_en[CH];
   int m_sum;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            m_sh_step[c] = 0; m_sh_m1[c] = 0; m_sh_yf[c] = 0; m_sh_inc[c] = 0; m_ptr[c] = 0;
            m_step[c] = 0; m_m1[c] = 0; m_yf[c] = 0; m_inc[c] = 0; m_acc[c] = 0; m_en[c] = 0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (bus.COMMIT) begin
               m_step[c] = m_sh_step[c]; m_m1[c] = m_sh_m1[c];
               m_yf[c] = m_sh_yf[c]; m_inc[c] = m_sh_inc[c];
               m_acc[c] = 0; m_en[c] = 0;
            end else if (bus.ADV[c]) begin
               if (m_yf[c] != 0) begin
                  m_sum = m_acc[c] + m_inc[c];
                  m_en[c] = (m_sum >= 256) ? 1 : 0;
                  m_acc[c] = m_sum % 256;
               end else begin
                  m_en[c] = 1;
               end
            end else begin
               m_en[c] = 0;
            end
            if (int'(bus.CHSEL) == c) begin
               if (bus.LDMOD) begin
                  m_sh_m1[c] = int'(bus.ID[0]);
                  m_sh_yf[c] = int'(bus.ID[4]);
                  m_ptr[c] = 0;
               end
               if (bus.LDSTP) begin
                  m_sh_step[c] = (m_sh_step[c] & ~(32'hFF << (8*m_ptr[c])))
                                 | (int'(bus.ID) << (8*m_ptr[c]));
                  m_ptr[c] = (m_ptr[c] + 1) % NBY;
               end
               if (bus.LDINC) m_sh_inc[c] = int'(bus.ID);
            end
         end
      end
   end

   function automatic logic [CH*SW-1:0] exp_step();
      logic [CH*SW-1:0] v = '0;
      for (int c = 0; c < CH; c++) v[c*SW +: SW] = SW'(m_step[c]);
      return v;
   endfunction

   function automatic logic [CH-1:0] exp_bits(input int sel);
      logic [CH-1:0] v = '0;
      for (int c = 0; c < CH; c++)
         v[c] = (sel == 0) ? (m_m1[c] != 0) : (sel == 1) ? (m_yf[c] != 0) : (m_en[c] != 0);
      return v;
   endfunction

   always @(negedge clk) begin
      check("model_step",    64'(bus.STEP),    64'(exp_step()));
      check("model_stepm1",  64'(bus.STEPM1),  64'(exp_bits(0)));
      check("model_yfrac",   64'(bus.YFRAC),   64'(exp_bits(1)));
      check("model_step_en", 64'(bus.STEP_EN), 64'(exp_bits(2)));
   end

   // Drive one cycle of inputs, hold across the edge, then return strobes to 0.
   task automatic drive(input logic [1:0] chsel, input logic [7:0] id,
                        input logic ldstp, input logic ldmod, input logic ldinc,
                        input logic commit, input logic [CH-1:0] adv);
      bus.CHSEL = chsel; bus.ID = id; bus.LDSTP = ldstp; bus.LDMOD = ldmod;
      bus.LDINC = ldinc; bus.COMMIT = commit; bus.ADV = adv;
      @(posedge clk);
      #1;
      bus.LDSTP = 1'b0; bus.LDMOD = 1'b0; bus.LDINC = 1'b0;
      bus.COMMIT = 1'b0; bus.ADV = '0; bus.ID = 8'h00; bus.CHSEL = 2'd0;
   endtask

   logic [7:0] pat;
   int         pulses;

   initial begin
      bus.CHSEL = 2'd0; bus.ID = 8'h00; bus.LDSTP = 1'b0; bus.LDMOD = 1'b0;
      bus.LDINC = 1'b0; bus.COMMIT = 1'b0; bus.ADV = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_step",   64'(bus.STEP),    64'h0);
      check("reset_flags",  64'({bus.STEPM1, bus.YFRAC, bus.STEP_EN}), 64'h0);
      rst = 1'b0;
      drive(0, 8'h00, 0, 0, 0, 0, 2'b00);

      // Two-byte load on channel 1, visible only after COMMIT.
      drive(1, 8'h01, 0, 1, 0, 0, 2'b00);
      drive(1, 8'h34, 1, 0, 0, 0, 2'b00);
      drive(1, 8'h12, 1, 0, 0, 0, 2'b00);
      check("shadow_hidden", 64'(bus.STEP), 64'h0);
      drive(0, 8'h00, 0, 0, 0, 1, 2'b00);
      check("commit_step",   64'(bus.STEP),   64'h1234_0000);
      check("commit_stepm1", 64'(bus.STEPM1), 64'h2);

      // Fractional mode, inc 0x40: carry on every 4th ADV.
      drive(0, 8'h10, 0, 1, 0, 0, 2'b00);
      drive(0, 8'h40, 0, 0, 1, 0, 2'b00);
      drive(0, 8'h00, 0, 0, 0, 1, 2'b00);
      check("frac_yfrac", 64'(bus.YFRAC), 64'h1);
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         drive(0, 8'h00, 0, 0, 0, 0, 2'b01);
         pat[i] = bus.STEP_EN[0];
      end
      check("frac_pattern", 64'(pat), 64'h88);
      drive(0, 8'h00, 0, 0, 0, 0, 2'b00);

      // Integer mode on channel 1: ADV 1,1,0,1,0 echoed one cycle later.
      pat = '0;
      for (int i = 0; i < 5; i++) begin
         drive(0, 8'h00, 0, 0, 0, 0, {((5'b01011 >> i) & 5'd1) != 0, 1'b0});
         pat[i] = bus.STEP_EN[1];
      end
      check("int_pattern", 64'(pat), 64'h0B);

      // Load coincident with COMMIT touches only the shadow.
      drive(0, 8'h10, 0, 1, 0, 0, 2'b00);
      drive(0, 8'h05, 1, 0, 0, 0, 2'b00);
      drive(0, 8'h00, 1, 0, 0, 0, 2'b00);
      drive(0, 8'h00, 0, 0, 0, 1, 2'b00);
      check("step_05", 64'(bus.STEP[15:0]), 64'h0005);
      drive(0, 8'h10, 0, 1, 0, 0, 2'b00);
      drive(0, 8'h09, 1, 0, 0, 1, 2'b00);
      check("coincident_load", 64'(bus.STEP[15:0]), 64'h0005);
      drive(0, 8'h00, 0, 0, 0, 1, 2'b00);
      check("second_commit", 64'(bus.STEP[15:0]), 64'h0009);

      // inc 0x80; ADV coincident with COMMIT clears the accumulator.
      drive(0, 8'h80, 0, 0, 1, 0, 2'b00);
      drive(0, 8'h00, 0, 0, 0, 1, 2'b00);
      pat = '0;
      drive(0, 8'h00, 0, 0, 0, 0, 2'b01); pat[0] = bus.STEP_EN[0];
      drive(0, 8'h00, 0, 0, 0, 1, 2'b01); pat[1] = bus.STEP_EN[0];
      drive(0, 8'h00, 0, 0, 0, 0, 2'b01); pat[2] = bus.STEP_EN[0];
      drive(0, 8'h00, 0, 0, 0, 0, 2'b01); pat[3] = bus.STEP_EN[0];
      check("commit_vs_adv", 64'(pat), 64'h8);

      // Zero increment never pulses.
      drive(0, 8'h00, 0, 0, 1, 0, 2'b00);
      drive(0, 8'h00, 0, 0, 0, 1, 2'b00);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 8'h00, 0, 0, 0, 0, 2'b01);
         pulses += int'(bus.STEP_EN[0]);
      end
      check("zero_inc", 64'(pulses), 64'h0);

      // Out-of-range CHSEL strobes are ignored.
      drive(2, 8'hFF, 1, 1, 1, 0, 2'b00);
      drive(3, 8'hEE, 1, 1, 1, 0, 2'b00);
      drive(0, 8'h00, 0, 0, 0, 1, 2'b00);
      check("bad_chsel_step",  64'(bus.STEP), 64'h1234_0009);
      check("bad_chsel_flags", 64'({bus.STEPM1, bus.YFRAC}), 64'h9);

      // Same-cycle LDMOD + LDSTP: byte lands in byte 0, next byte in byte 1.
      drive(1, 8'h77, 1, 0, 0, 0, 2'b00);
      drive(1, 8'h11, 1, 1, 0, 0, 2'b00);
      drive(1, 8'hAB, 1, 0, 0, 0, 2'b00);
      drive(0, 8'h00, 0, 0, 0, 1, 2'b00);
      check("mod_stp_step",  64'(bus.STEP), 64'hAB11_0009);
      check("mod_stp_flags", 64'({bus.STEPM1, bus.YFRAC}), 64'hB);

      // Reset in the middle of a two-byte load.
      drive(0, 8'h10, 0, 1, 0, 0, 2'b00);
      drive(0, 8'h11, 1, 0, 0, 0, 2'b00);
      rst = 1'b1;
      #2;
      check("async_reset_step",  64'(bus.STEP), 64'h0);
      check("async_reset_flags", 64'({bus.STEPM1, bus.YFRAC, bus.STEP_EN}), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 8'hAA, 1, 0, 0, 0, 2'b00);
      drive(0, 8'h55, 1, 0, 0, 0, 2'b00);
      drive(0, 8'h00, 0, 0, 0, 1, 2'b00);
      check("reload_after_reset", 64'(bus.STEP), 64'h0000_55AA);
      drive(0, 8'h00, 0, 0, 0, 0, 2'b00);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
